// File: rtl/vc_rx_router.sv
// -----------------------------------------------------------------------------
// vc_rx_router
//  Receives words popped from the shared main FIFO and steers each one by its
//  class bit into one of two per-VC circular FIFOs (VC0 / VC1). Returns
//  registered pause signals that gate the upstream pop, and exposes registered
//  read ports that the next stage uses to drain each VC.
//
//  Optional feature macro: VC_RX_HYST_EN
//    defined   : pause_vcN is a RUN/PAUSED SR machine. It sets at
//                cnt_next >= AF_THRESH and clears at cnt_next <= AE_THRESH.
//    undefined : pause_vcN <= (cnt_next >= AF_THRESH).
//
//  Ports
//    clk            in   rising-edge clock
//    reset_L        in   asynchronous active-low reset
//    valid_in       in   data_in is valid (one push)
//    data_in        in   word from main FIFO; bit VC_SEL_BIT selects the VC
//    pop_vc0/1      in   read request per VC
//    data_out_vc0/1 out  registered read data
//    valid_out_vc0/1out  one-cycle pulse per accepted pop
//    empty_vc0/1    out  occupancy == 0 (combinational from count)
//    pause_vc0/1    out  registered backpressure to upstream pop logic
//    overflow_err   out  sticky: a push hit a full VC FIFO
// -----------------------------------------------------------------------------
module vc_rx_router #(
   parameter int DATA_W     = 6,
   parameter int VC_SEL_BIT = 4,
   parameter int ADDR_W     = 2,
   parameter int AF_THRESH  = 2,
   parameter int AE_THRESH  = 1
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop_vc0,
   input  logic              pop_vc1,
   output logic [DATA_W-1:0] data_out_vc0,
   output logic [DATA_W-1:0] data_out_vc1,
   output logic              valid_out_vc0,
   output logic              valid_out_vc1,
   output logic              empty_vc0,
   output logic              empty_vc1,
   output logic              pause_vc0,
   output logic              pause_vc1,
   output logic              overflow_err
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_INC_C = {{(ADDR_W-1){1'b0}}, 1'b1};

   // At most one word is in flight after pause rises, so two free slots are
   // needed above the threshold; release must sit below the set point.
   if ((DEPTH - AF_THRESH) < 2 || AE_THRESH >= AF_THRESH) begin : g_bad_thresh
      $error("vc_rx_router: illegal AF_THRESH/AE_THRESH for this DEPTH");
   end

   logic [DATA_W-1:0] mem_r     [2][DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r  [2];
   logic [ADDR_W-1:0] rd_ptr_r  [2];
   logic [ADDR_W:0]   cnt_r     [2];
   logic [ADDR_W:0]   cnt_next_s[2];
   logic [DATA_W-1:0] dout_r    [2];
   logic [1:0]        vout_r;
   logic [1:0]        push_s;
   logic [1:0]        pop_s;
   logic [1:0]        pop_req_s;
   logic              overflow_hit_s;
   logic              overflow_r;
   logic [1:0]        pause_s;

   assign pop_req_s = {pop_vc1, pop_vc0};

   // Per-VC push/pop qualification and next occupancy
   always_comb begin
      push_s         = 2'b00;
      pop_s          = 2'b00;
      overflow_hit_s = 1'b0;
      for (int v = 0; v < 2; v++) begin
         cnt_next_s[v] = cnt_r[v];
         if (valid_in && (data_in[VC_SEL_BIT] == v[0])) begin
            if (cnt_r[v] == DEPTH_C) begin
               overflow_hit_s = 1'b1;
            end else begin
               push_s[v] = 1'b1;
            end
         end else begin
            push_s[v] = 1'b0;
         end
         // Pop qualifies on current occupancy: a push in the same cycle
         // onto an empty VC is not visible to this pop.
         pop_s[v] = pop_req_s[v] && (cnt_r[v] != ZERO_C);
         if (push_s[v] && !pop_s[v]) begin
            cnt_next_s[v] = cnt_r[v] + ONE_C;
         end else if (!push_s[v] && pop_s[v]) begin
            cnt_next_s[v] = cnt_r[v] - ONE_C;
         end else begin
            cnt_next_s[v] = cnt_r[v];
         end
      end
   end

   // Storage array write port (no reset needed on data storage)
   always_ff @(posedge clk) begin
      for (int v = 0; v < 2; v++) begin
         if (push_s[v]) begin
            mem_r[v][wr_ptr_r[v]] <= data_in;
         end
      end
   end

   // Pointers, counts, read port registers and sticky overflow flag
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int v = 0; v < 2; v++) begin
            wr_ptr_r[v] <= {ADDR_W{1'b0}};
            rd_ptr_r[v] <= {ADDR_W{1'b0}};
            cnt_r[v]    <= ZERO_C;
            dout_r[v]   <= {DATA_W{1'b0}};
         end
         vout_r     <= 2'b00;
         overflow_r <= 1'b0;
      end else begin
         for (int v = 0; v < 2; v++) begin
            cnt_r[v] <= cnt_next_s[v];
            if (push_s[v]) begin
               wr_ptr_r[v] <= wr_ptr_r[v] + PTR_INC_C;
            end
            if (pop_s[v]) begin
               dout_r[v]   <= mem_r[v][rd_ptr_r[v]];
               rd_ptr_r[v] <= rd_ptr_r[v] + PTR_INC_C;
            end
            vout_r[v] <= pop_s[v];
         end
         if (overflow_hit_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

`ifdef VC_RX_HYST_EN
   typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} pause_state_e;

   localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_THRESH);

   pause_state_e state_r      [2];
   pause_state_e state_next_s [2];

   // Pause state register per VC
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_r[0] <= RUN;
         state_r[1] <= RUN;
      end else begin
         state_r[0] <= state_next_s[0];
         state_r[1] <= state_next_s[1];
      end
   end

   // Pause next-state: set at almost-full, release only at almost-empty
   always_comb begin
      for (int v = 0; v < 2; v++) begin
         state_next_s[v] = state_r[v];
         case (state_r[v])
            RUN: begin
               if (cnt_next_s[v] >= AF_C) begin
                  state_next_s[v] = PAUSED;
               end else begin
                  state_next_s[v] = RUN;
               end
            end
            PAUSED: begin
               if (cnt_next_s[v] <= AE_C) begin
                  state_next_s[v] = RUN;
               end else begin
                  state_next_s[v] = PAUSED;
               end
            end
            default: state_next_s[v] = RUN;
         endcase
      end
   end

   assign pause_s = {state_r[1] == PAUSED, state_r[0] == PAUSED};
`else
   logic [1:0] pause_r;

   // Pause follows next occupancy against the almost-full threshold
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         pause_r <= 2'b00;
      end else begin
         pause_r <= {cnt_next_s[1] >= AF_C, cnt_next_s[0] >= AF_C};
      end
   end

   assign pause_s = pause_r;
`endif

   assign data_out_vc0  = dout_r[0];
   assign data_out_vc1  = dout_r[1];
   assign valid_out_vc0 = vout_r[0];
   assign valid_out_vc1 = vout_r[1];
   assign empty_vc0     = (cnt_r[0] == ZERO_C);
   assign empty_vc1     = (cnt_r[1] == ZERO_C);
   assign pause_vc0     = pause_s[0];
   assign pause_vc1     = pause_s[1];
   assign overflow_err  = overflow_r;

endmodule

// File: tb/tb_vc_rx_router.sv
// -----------------------------------------------------------------------------
// tb_vc_rx_router
//  Directed-vector bench for vc_rx_router (default parameters, DEPTH = 4).
//  Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_vc_rx_router;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       valid_in;
   logic [5:0] data_in;
   logic       pop_vc0;
   logic       pop_vc1;
   logic [5:0] data_out_vc0;
   logic [5:0] data_out_vc1;
   logic       valid_out_vc0;
   logic       valid_out_vc1;
   logic       empty_vc0;
   logic       empty_vc1;
   logic       pause_vc0;
   logic       pause_vc1;
   logic       overflow_err;

   int n_vec = 0;
   int n_err = 0;

   vc_rx_router dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .pop_vc0      (pop_vc0),
      .pop_vc1      (pop_vc1),
      .data_out_vc0 (data_out_vc0),
      .data_out_vc1 (data_out_vc1),
      .valid_out_vc0(valid_out_vc0),
      .valid_out_vc1(valid_out_vc1),
      .empty_vc0    (empty_vc0),
      .empty_vc1    (empty_vc1),
      .pause_vc0    (pause_vc0),
      .pause_vc1    (pause_vc1),
      .overflow_err (overflow_err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; outputs of that edge are stable on return
   task automatic cyc(input logic vin, input logic [5:0] din, input logic p0, input logic p1);
      valid_in = vin;
      data_in  = din;
      pop_vc0  = p0;
      pop_vc1  = p1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      pop_vc0  = 1'b0;
      pop_vc1  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_dout0"}, 32'(data_out_vc0), 32'h0);
      check_eq({tag, "_dout1"}, 32'(data_out_vc1), 32'h0);
      check_eq({tag, "_vout0"}, 32'(valid_out_vc0), 32'h0);
      check_eq({tag, "_vout1"}, 32'(valid_out_vc1), 32'h0);
      check_eq({tag, "_empty0"}, 32'(empty_vc0), 32'h1);
      check_eq({tag, "_empty1"}, 32'(empty_vc1), 32'h1);
      check_eq({tag, "_pause0"}, 32'(pause_vc0), 32'h0);
      check_eq({tag, "_pause1"}, 32'(pause_vc1), 32'h0);
      check_eq({tag, "_ovf"}, 32'(overflow_err), 32'h0);
   endtask

   initial begin
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 6'h00;
      pop_vc0  = 1'b0;
      pop_vc1  = 1'b0;
      #1;
      check_reset_state("init");
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;

      // Steering: 0x12 has bit 4 set -> VC1
      cyc(1'b1, 6'h01, 1'b0, 1'b0);
      cyc(1'b1, 6'h12, 1'b0, 1'b0);
      cyc(1'b1, 6'h03, 1'b0, 1'b0);
      check_eq("steer_empty0", 32'(empty_vc0), 32'h0);
      check_eq("steer_empty1", 32'(empty_vc1), 32'h0);
      cyc(1'b0, 6'h00, 1'b1, 1'b1);
      check_eq("steer_v0a", 32'(valid_out_vc0), 32'h1);
      check_eq("steer_d0a", 32'(data_out_vc0), 32'h01);
      check_eq("steer_v1", 32'(valid_out_vc1), 32'h1);
      check_eq("steer_d1", 32'(data_out_vc1), 32'h12);
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("steer_v0b", 32'(valid_out_vc0), 32'h1);
      check_eq("steer_d0b", 32'(data_out_vc0), 32'h03);
      check_eq("steer_v1_off", 32'(valid_out_vc1), 32'h0);
      cyc(1'b0, 6'h00, 1'b0, 1'b0);
      check_eq("steer_v0_pulse", 32'(valid_out_vc0), 32'h0);
      check_eq("steer_d0_hold", 32'(data_out_vc0), 32'h03);
      check_eq("steer_empty0_end", 32'(empty_vc0), 32'h1);

      // Pause threshold on VC0 only
      cyc(1'b1, 6'h05, 1'b0, 1'b0);
      check_eq("pause_after1", 32'(pause_vc0), 32'h0);
      cyc(1'b1, 6'h06, 1'b0, 1'b0);
      check_eq("pause_after2", 32'(pause_vc0), 32'h1);
      check_eq("pause_other", 32'(pause_vc1), 32'h0);
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      // occupancy 1 is below AF and at AE, so both builds release here
      check_eq("pause_release", 32'(pause_vc0), 32'h0);
      check_eq("pause_pop_d", 32'(data_out_vc0), 32'h05);
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("pause_pop_d2", 32'(data_out_vc0), 32'h06);

      // Overflow on VC1: fifth push dropped
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 6'(8'h10 + i), 1'b0, 1'b0);
         if (i == 3) check_eq("ovf_before", 32'(overflow_err), 32'h0);
      end
      check_eq("ovf_set", 32'(overflow_err), 32'h1);
      check_eq("ovf_pause1", 32'(pause_vc1), 32'h1);
      check_eq("ovf_pause0", 32'(pause_vc0), 32'h0);
      cyc(1'b0, 6'h00, 1'b0, 1'b0);
      check_eq("ovf_sticky", 32'(overflow_err), 32'h1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 6'h00, 1'b0, 1'b1);
         check_eq("ovf_drain_v", 32'(valid_out_vc1), 32'h1);
         check_eq("ovf_drain_d", 32'(data_out_vc1), 32'h10 + 32'(i));
      end
      cyc(1'b0, 6'h00, 1'b0, 1'b1);
      check_eq("ovf_drain_empty_v", 32'(valid_out_vc1), 32'h0);
      check_eq("ovf_drain_hold_d", 32'(data_out_vc1), 32'h13);
      check_eq("ovf_empty1", 32'(empty_vc1), 32'h1);
      check_eq("ovf_sticky2", 32'(overflow_err), 32'h1);

      // Steady push+pop at occupancy 2 across the pointer wrap
      cyc(1'b1, 6'h01, 1'b0, 1'b0);
      cyc(1'b1, 6'h02, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 6'(i + 3), 1'b1, 1'b0);
         check_eq("wrap_v", 32'(valid_out_vc0), 32'h1);
         check_eq("wrap_d", 32'(data_out_vc0), 32'(i + 1));
         check_eq("wrap_pause", 32'(pause_vc0), 32'h1);
      end
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("wrap_tail_a", 32'(data_out_vc0), 32'h07);
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("wrap_tail_b", 32'(data_out_vc0), 32'h08);
      check_eq("wrap_empty0", 32'(empty_vc0), 32'h1);

      // Pop on empty, then push+pop on empty in the same cycle
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("empty_pop_v", 32'(valid_out_vc0), 32'h0);
      check_eq("empty_pop_d", 32'(data_out_vc0), 32'h08);
      cyc(1'b1, 6'h0A, 1'b1, 1'b0);
      check_eq("empty_pp_v", 32'(valid_out_vc0), 32'h0);
      check_eq("empty_pp_d", 32'(data_out_vc0), 32'h08);
      check_eq("empty_pp_e", 32'(empty_vc0), 32'h0);
      cyc(1'b0, 6'h00, 1'b1, 1'b0);
      check_eq("empty_pp_v2", 32'(valid_out_vc0), 32'h1);
      check_eq("empty_pp_d2", 32'(data_out_vc0), 32'h0A);

      // Asynchronous reset in the middle of traffic
      cyc(1'b1, 6'h01, 1'b0, 1'b0);
      cyc(1'b1, 6'h12, 1'b0, 1'b0);
      cyc(1'b1, 6'h02, 1'b1, 1'b1);
      check_eq("mid_v0", 32'(valid_out_vc0), 32'h1);
      check_eq("mid_v1", 32'(valid_out_vc1), 32'h1);
      reset_L = 1'b0;
      #1;
      check_reset_state("midrst");
      @(posedge clk);
      #1;
      reset_L = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
